execute_stage: RTL and testbench

Execute stage of the 16-bit five-stage pipeline, directly downstream of the decode/execute buffer. Consumes the buffered operands and control bits, forwards operands from later stages, computes the ALU result, maintains the condition-code register (CCR), resolves conditional branches and drives a flush request to the front end. Results are registered into the execute/memory buffer, which is part of this block.

---
 rtl/execute_stage_pkg.sv | 40 ++++
 rtl/execute_stage_if.sv | 14 +
 rtl/execute_stage_alu_unit.sv | 54 +++++
 rtl/execute_stage.sv | 133 +++++++++++++
 tb/tb_execute_stage.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/execute_stage_pkg.sv
// execute_stage_pkg: shared ALU op codes, branch conditions, flag indices and defaults
//   for the execute stage and its ALU.
package execute_stage_pkg;

    localparam int FLUSH_DEPTH_DEF = 2;

    // CCR bit positions; CCR reads {C,N,Z}
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;

    typedef enum logic [3:0] {
        OP_PASSA = 4'd0,
        OP_NOT   = 4'd1,
        OP_INC   = 4'd2,
        OP_DEC   = 4'd3,
        OP_ADD   = 4'd4,
        OP_SUB   = 4'd5,
        OP_AND   = 4'd6,
        OP_OR    = 4'd7,
        OP_SHL   = 4'd8,
        OP_SHR   = 4'd9,
        OP_PASSB = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        BR_Z      = 2'd0,
        BR_N      = 2'd1,
        BR_C      = 2'd2,
        BR_ALWAYS = 2'd3
    } br_cond_e;

    typedef struct packed {
        logic mr;
        logic mw;
        logic mtr;
        logic rw;
    } em_ctrl_t;

endpackage

// File: rtl/execute_stage_if.sv
// execute_stage_if: forwarding bus from the MEM and WB stages into execute.
//   FwdEMRW/FwdEMDest/FwdEMData : write enable, destination, data of the MEM instruction
//   FwdMWRW/FwdMWDest/FwdMWData : write enable, destination, data of the WB instruction
interface execute_stage_if #(parameter int WIDTH = 16);
    logic             FwdEMRW;
    logic             FwdMWRW;
    logic [2:0]       FwdEMDest;
    logic [2:0]       FwdMWDest;
    logic [WIDTH-1:0] FwdEMData;
    logic [WIDTH-1:0] FwdMWData;

    modport master (output FwdEMRW, FwdMWRW, FwdEMDest, FwdMWDest, FwdEMData, FwdMWData);
    modport slave  (input  FwdEMRW, FwdMWRW, FwdEMDest, FwdMWDest, FwdEMData, FwdMWData);
endinterface

// File: rtl/execute_stage_alu_unit.sv
// alu_unit: combinational ALU with carry/sign/zero and flag update masks.
//   a_i, b_i : operands        op_i : operation      shamt_i : shift amount
//   c_i      : current carry   result_o, c_o, n_o, z_o : result and flags
//   upd_zn_o, upd_c_o : which flags this op is allowed to update
module alu_unit
    import execute_stage_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       op_i,
    input  logic [3:0]       shamt_i,
    input  logic             c_i,
    output logic [WIDTH-1:0] result_o,
    output logic             c_o,
    output logic             n_o,
    output logic             z_o,
    output logic             upd_zn_o,
    output logic             upd_c_o
);

    logic [WIDTH:0] wide, shl_w, shr_w;

    // Extra bit catches the last bit shifted out: top bit for SHL, bottom bit for SHR
    assign shl_w = {1'b0, b_i} << shamt_i;
    assign shr_w = {b_i, 1'b0} >> shamt_i;

    always_comb begin
        wide = {1'b0, a_i};
        case (op_i)
            OP_NOT:   wide = {1'b0, ~a_i};
            OP_INC:   wide = {1'b0, a_i} + (WIDTH+1)'(1);
            OP_DEC:   wide = {1'b0, a_i} - (WIDTH+1)'(1);
            OP_ADD:   wide = {1'b0, a_i} + {1'b0, b_i};
            OP_SUB:   wide = {1'b0, b_i} - {1'b0, a_i};
            OP_AND:   wide = {1'b0, a_i & b_i};
            OP_OR:    wide = {1'b0, a_i | b_i};
            OP_SHL:   wide = shl_w;
            OP_SHR:   wide = {shr_w[0], shr_w[WIDTH:1]};
            OP_PASSB: wide = {1'b0, b_i};
            default:  wide = {1'b0, a_i};
        endcase
    end

    assign result_o = wide[WIDTH-1:0];
    // A zero-length shift shifts nothing out, so carry is kept
    assign c_o      = ((op_i == OP_SHL || op_i == OP_SHR) && shamt_i == 4'd0) ? c_i : wide[WIDTH];
    assign n_o      = result_o[WIDTH-1];
    assign z_o      = result_o == '0;
    assign upd_zn_o = op_i >= OP_NOT && op_i <= OP_SHR;
    assign upd_c_o  = (op_i >= OP_INC && op_i <= OP_SUB) || op_i == OP_SHL || op_i == OP_SHR;

endmodule

// File: rtl/execute_stage.sv
// execute_stage: operand forwarding, ALU, CCR, branch resolution, flush counter and EM buffer.
//   Clk, Rst_n       : clock (state on negedge), async active-low reset
//   fwd              : forwarding bus from MEM/WB
//   Reg1..FlashNumIn : buffered decode/execute operands and controls
//   EM*              : registered execute/memory buffer
//   CCR              : {C,N,Z}
//   BranchTaken/Target : combinational branch resolution
//   FlushCount       : younger instructions still to squash
module execute_stage
    import execute_stage_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int FLUSH_DEPTH = FLUSH_DEPTH_DEF
) (
    input  logic             Clk,
    input  logic             Rst_n,
    execute_stage_if.slave   fwd,
    input  logic [WIDTH-1:0] Reg1,
    input  logic [WIDTH-1:0] Reg2,
    input  logic [WIDTH-1:0] instr,
    input  logic [4:0]       Instruction,
    input  logic [2:0]       SrcAddress,
    input  logic [2:0]       RegDestination,
    input  logic [3:0]       aluSignals,
    input  logic             ALU_src,
    input  logic             shift,
    input  logic             MR,
    input  logic             MW,
    input  logic             MTR,
    input  logic             RW,
    input  logic             Branch,
    input  logic             SetC,
    input  logic             CLRC,
    input  logic [1:0]       FlashNumIn,
    output logic [WIDTH-1:0] EMResult,
    output logic [WIDTH-1:0] EMStoreData,
    output logic [2:0]       EMDest,
    output logic             EMMR,
    output logic             EMMW,
    output logic             EMMTR,
    output logic             EMRW,
    output logic [2:0]       CCR,
    output logic             BranchTaken,
    output logic [WIDTH-1:0] BranchTarget,
    output logic [1:0]       FlushCount
);

    logic [WIDTH-1:0] op_a, op_b_fwd, op_b, alu_res, res_q, store_q;
    logic [2:0]       ccr_q, ccr_d, dest_q;
    logic [1:0]       flush_q, flush_d;
    em_ctrl_t         ctrl_q, ctrl_d;
    logic             alu_c, alu_n, alu_z, upd_zn, upd_c, valid, cond, clr_flag;
    logic             unused_bits;

    // Opcode bits above the condition field and the shift flag carry nothing extra here
    assign unused_bits = ^{shift, Instruction[4:2]};

    assign op_a = (fwd.FwdEMRW && fwd.FwdEMDest == SrcAddress) ? fwd.FwdEMData :
                  (fwd.FwdMWRW && fwd.FwdMWDest == SrcAddress) ? fwd.FwdMWData : Reg1;
    assign op_b_fwd = (fwd.FwdEMRW && fwd.FwdEMDest == RegDestination) ? fwd.FwdEMData :
                      (fwd.FwdMWRW && fwd.FwdMWDest == RegDestination) ? fwd.FwdMWData : Reg2;
    assign op_b = ALU_src ? instr : op_b_fwd;

    alu_unit #(.WIDTH(WIDTH)) u_alu (
        .a_i      (op_a),
        .b_i      (op_b),
        .op_i     (aluSignals),
        .shamt_i  (instr[3:0]),
        .c_i      (ccr_q[FLAG_C]),
        .result_o (alu_res),
        .c_o      (alu_c),
        .n_o      (alu_n),
        .z_o      (alu_z),
        .upd_zn_o (upd_zn),
        .upd_c_o  (upd_c)
    );

    assign valid = FlashNumIn == 2'd0 && flush_q == 2'd0;
    // Condition reads the CCR as it stood before this instruction
    assign cond  = Instruction[1:0] == BR_ALWAYS ? 1'b1 :
                   Instruction[1:0] == BR_C      ? ccr_q[FLAG_C] :
                   Instruction[1:0] == BR_N      ? ccr_q[FLAG_N] : ccr_q[FLAG_Z];
    assign BranchTaken  = valid && Branch && cond;
    assign BranchTarget = op_a;
    assign clr_flag     = BranchTaken && Instruction[1:0] != BR_ALWAYS;

    always_comb begin
        ccr_d = ccr_q;
        if (valid) begin
            if (upd_zn) begin
                ccr_d[FLAG_Z] = alu_z;
                ccr_d[FLAG_N] = alu_n;
            end
            if (upd_c) ccr_d[FLAG_C] = alu_c;
            if (CLRC) ccr_d[FLAG_C] = 1'b0;
            if (SetC) ccr_d[FLAG_C] = 1'b1;
            // Condition codes 0..2 line up with the Z/N/C bit positions
            ccr_d = ccr_d & ~({2'b00, clr_flag} << Instruction[1:0]);
        end
    end

    assign flush_d = BranchTaken ? 2'(FLUSH_DEPTH) : flush_q != 2'd0 ? flush_q - 2'd1 : 2'd0;
    assign ctrl_d  = valid ? {MR, MW, MTR, RW} : '0;

    always_ff @(negedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ccr_q   <= '0;
            flush_q <= '0;
            res_q   <= '0;
            store_q <= '0;
            dest_q  <= '0;
            ctrl_q  <= '0;
        end else begin
            ccr_q   <= ccr_d;
            flush_q <= flush_d;
            res_q   <= alu_res;
            store_q <= op_b_fwd;
            dest_q  <= RegDestination;
            ctrl_q  <= ctrl_d;
        end
    end

    assign EMResult    = res_q;
    assign EMStoreData = store_q;
    assign EMDest      = dest_q;
    assign EMMR        = ctrl_q.mr;
    assign EMMW        = ctrl_q.mw;
    assign EMMTR       = ctrl_q.mtr;
    assign EMRW        = ctrl_q.rw;
    assign CCR         = ccr_q;
    assign FlushCount  = flush_q;

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed tests of forwarding, ALU flags, branch/flush, bubbles and reset.
module tb_execute_stage;

    logic        Clk, Rst_n;
    logic [15:0] Reg1, Reg2, instr;
    logic [4:0]  Instruction;
    logic [2:0]  SrcAddress, RegDestination;
    logic [3:0]  aluSignals;
    logic        ALU_src, shift, MR, MW, MTR, RW, Branch, SetC, CLRC;
    logic [1:0]  FlashNumIn;
    logic [15:0] EMResult, EMStoreData, BranchTarget;
    logic [2:0]  EMDest, CCR;
    logic        EMMR, EMMW, EMMTR, EMRW, BranchTaken;
    logic [1:0]  FlushCount;
    int          checks = 0;
    int          errors = 0;

    execute_stage_if #(.WIDTH(16)) fwd ();

    execute_stage dut (
        .Clk(Clk), .Rst_n(Rst_n), .fwd(fwd),
        .Reg1(Reg1), .Reg2(Reg2), .instr(instr), .Instruction(Instruction),
        .SrcAddress(SrcAddress), .RegDestination(RegDestination), .aluSignals(aluSignals),
        .ALU_src(ALU_src), .shift(shift), .MR(MR), .MW(MW), .MTR(MTR), .RW(RW),
        .Branch(Branch), .SetC(SetC), .CLRC(CLRC), .FlashNumIn(FlashNumIn),
        .EMResult(EMResult), .EMStoreData(EMStoreData), .EMDest(EMDest),
        .EMMR(EMMR), .EMMW(EMMW), .EMMTR(EMMTR), .EMRW(EMRW), .CCR(CCR),
        .BranchTaken(BranchTaken), .BranchTarget(BranchTarget), .FlushCount(FlushCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #100000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end

    task automatic clr();
        Reg1 = 0; Reg2 = 0; instr = 0; Instruction = 0; SrcAddress = 0; RegDestination = 0;
        aluSignals = 0; ALU_src = 0; shift = 0; MR = 0; MW = 0; MTR = 0; RW = 0;
        Branch = 0; SetC = 0; CLRC = 0; FlashNumIn = 0;
        fwd.FwdEMRW = 0; fwd.FwdMWRW = 0; fwd.FwdEMDest = 0; fwd.FwdMWDest = 0;
        fwd.FwdEMData = 0; fwd.FwdMWData = 0;
        #1;
    endtask

    task automatic tick();
        @(negedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Rst_n = 1'b1;
        clr();
        tick();
        Rst_n = 1'b0;
        #1;
        checks++;
        if ({CCR, FlushCount, EMRW, EMResult} !== 22'd0) begin
            errors++;
            $display("FAIL reset_init got ccr=%b flush=%0d rw=%b res=%h want 0", CCR, FlushCount, EMRW, EMResult);
        end
        tick();
        Rst_n = 1'b1;
    endtask

    task automatic test_mid_reset();
        clr();
        aluSignals = 4'd1; SetC = 1; RW = 1; MW = 1; Reg2 = 16'h1234; RegDestination = 3'd5;
        tick();
        checks++;
        if (CCR !== 3'b110) begin errors++; $display("FAIL midrst_ccr got %b want 110", CCR); end
        clr();
        Branch = 1; Instruction = 5'b00011;
        tick();
        checks++;
        if (FlushCount !== 2'd2 || CCR !== 3'b110) begin
            errors++;
            $display("FAIL midrst_flush got flush=%0d ccr=%b want 2 110", FlushCount, CCR);
        end
        Rst_n = 1'b0;
        #1;
        checks++;
        if ({CCR, FlushCount, EMResult, EMStoreData, EMDest, EMMR, EMMW, EMMTR, EMRW} !== 44'd0) begin
            errors++;
            $display("FAIL midrst_zero got ccr=%b flush=%0d res=%h st=%h dest=%0d ctl=%b%b%b%b want 0",
                     CCR, FlushCount, EMResult, EMStoreData, EMDest, EMMR, EMMW, EMMTR, EMRW);
        end
        Rst_n = 1'b1;
    endtask

    task automatic test_alu();
        clr();
        Reg1 = 16'h7FFF; Reg2 = 16'h0001; aluSignals = 4'd4; RW = 1; RegDestination = 3'd2;
        tick();
        checks++;
        if (EMResult !== 16'h8000 || CCR !== 3'b010) begin
            errors++;
            $display("FAIL add got res=%h ccr=%b want 8000 010", EMResult, CCR);
        end
        checks++;
        if (EMRW !== 1'b1 || EMDest !== 3'd2 || EMStoreData !== 16'h0001) begin
            errors++;
            $display("FAIL add_em got rw=%b dest=%0d st=%h want 1 2 0001", EMRW, EMDest, EMStoreData);
        end
        clr();
        Reg1 = 16'd3; Reg2 = 16'h0AAA; instr = 16'd5; ALU_src = 1; aluSignals = 4'd5;
        tick();
        checks++;
        if (EMResult !== 16'd2 || CCR !== 3'b000 || EMStoreData !== 16'h0AAA) begin
            errors++;
            $display("FAIL sub_imm got res=%h ccr=%b st=%h want 0002 000 0aaa", EMResult, CCR, EMStoreData);
        end
        clr();
        Reg1 = 16'd5; Reg2 = 16'd3; aluSignals = 4'd5;
        tick();
        checks++;
        if (EMResult !== 16'hFFFE || CCR !== 3'b110) begin
            errors++;
            $display("FAIL sub_borrow got res=%h ccr=%b want fffe 110", EMResult, CCR);
        end
    endtask

    task automatic test_forward();
        clr();
        SrcAddress = 3'd1; Reg1 = 16'h1111;
        fwd.FwdEMRW = 1; fwd.FwdEMDest = 3'd1; fwd.FwdEMData = 16'd5;
        fwd.FwdMWRW = 1; fwd.FwdMWDest = 3'd1; fwd.FwdMWData = 16'd9;
        tick();
        checks++;
        if (EMResult !== 16'd5) begin errors++; $display("FAIL fwd_em_prio got %h want 0005", EMResult); end
        fwd.FwdEMRW = 0;
        tick();
        checks++;
        if (EMResult !== 16'd9) begin errors++; $display("FAIL fwd_mw got %h want 0009", EMResult); end
        clr();
        RegDestination = 3'd4; Reg2 = 16'd7; aluSignals = 4'd10;
        fwd.FwdMWRW = 1; fwd.FwdMWDest = 3'd4; fwd.FwdMWData = 16'h00C3;
        tick();
        checks++;
        if (EMResult !== 16'h00C3 || EMStoreData !== 16'h00C3) begin
            errors++;
            $display("FAIL fwd_b got res=%h st=%h want 00c3 00c3", EMResult, EMStoreData);
        end
    endtask

    task automatic test_branch();
        clr();
        Reg1 = 16'd1; aluSignals = 4'd3;
        tick();
        checks++;
        if (CCR !== 3'b001) begin errors++; $display("FAIL br_setz got %b want 001", CCR); end
        clr();
        Branch = 1; Instruction = 5'b00010; Reg1 = 16'h0040; SrcAddress = 3'd3;
        #1;
        checks++;
        if (BranchTaken !== 1'b0) begin errors++; $display("FAIL br_not_taken got %b want 0", BranchTaken); end
        Instruction = 5'b00000;
        #1;
        checks++;
        if (BranchTaken !== 1'b1 || BranchTarget !== 16'h0040) begin
            errors++;
            $display("FAIL br_taken got taken=%b tgt=%h want 1 0040", BranchTaken, BranchTarget);
        end
        tick();
        checks++;
        if (CCR !== 3'b000 || FlushCount !== 2'd2) begin
            errors++;
            $display("FAIL br_after got ccr=%b flush=%0d want 000 2", CCR, FlushCount);
        end
        clr();
        Reg1 = 16'hFFFF; Reg2 = 16'd1; aluSignals = 4'd4; RW = 1; MW = 1; Branch = 1; Instruction = 5'b00011;
        #1;
        checks++;
        if (BranchTaken !== 1'b0) begin errors++; $display("FAIL br_squash_taken got %b want 0", BranchTaken); end
        tick();
        checks++;
        if (EMRW !== 1'b0 || EMMW !== 1'b0 || CCR !== 3'b000 || FlushCount !== 2'd1) begin
            errors++;
            $display("FAIL squash1 got rw=%b mw=%b ccr=%b flush=%0d want 0 0 000 1", EMRW, EMMW, CCR, FlushCount);
        end
        Branch = 0;
        tick();
        checks++;
        if (EMRW !== 1'b0 || EMMW !== 1'b0 || FlushCount !== 2'd0) begin
            errors++;
            $display("FAIL squash2 got rw=%b mw=%b flush=%0d want 0 0 0", EMRW, EMMW, FlushCount);
        end
        clr();
        Reg1 = 16'd2; Reg2 = 16'd3; aluSignals = 4'd4; RW = 1;
        tick();
        checks++;
        if (EMRW !== 1'b1 || EMResult !== 16'd5 || FlushCount !== 2'd0) begin
            errors++;
            $display("FAIL br_resume got rw=%b res=%h flush=%0d want 1 0005 0", EMRW, EMResult, FlushCount);
        end
    endtask

    task automatic test_setc_clrc();
        clr();
        Reg1 = 16'hFFFF; Reg2 = 16'd1; aluSignals = 4'd4; SetC = 1; CLRC = 1;
        tick();
        checks++;
        if (CCR !== 3'b101) begin errors++; $display("FAIL setc_clrc got %b want 101", CCR); end
        clr();
        Reg2 = 16'd3; aluSignals = 4'd9; instr = 16'd0;
        tick();
        checks++;
        if (EMResult !== 16'd3 || CCR !== 3'b100) begin
            errors++;
            $display("FAIL shr_zero got res=%h ccr=%b want 0003 100", EMResult, CCR);
        end
        clr();
        Reg2 = 16'h8000; aluSignals = 4'd8; instr = 16'd1; CLRC = 1;
        tick();
        checks++;
        if (EMResult !== 16'h0000 || CCR !== 3'b001) begin
            errors++;
            $display("FAIL shl_clrc got res=%h ccr=%b want 0000 001", EMResult, CCR);
        end
    endtask

    task automatic test_bubble();
        clr();
        FlashNumIn = 2'd1; RW = 1; Reg1 = 16'hFFFF; Reg2 = 16'd1; aluSignals = 4'd4;
        Branch = 1; Instruction = 5'b00011;
        #1;
        checks++;
        if (BranchTaken !== 1'b0) begin errors++; $display("FAIL bubble_branch got %b want 0", BranchTaken); end
        tick();
        checks++;
        if (EMRW !== 1'b0 || CCR !== 3'b001 || FlushCount !== 2'd0) begin
            errors++;
            $display("FAIL bubble got rw=%b ccr=%b flush=%0d want 0 001 0", EMRW, CCR, FlushCount);
        end
    endtask

    initial begin
        test_reset();
        test_mid_reset();
        test_alu();
        test_forward();
        test_branch();
        test_setc_clrc();
        test_bubble();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
